// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Drain stage for the ring FIFO. Pops one character at a time
//               from the FIFO's show-ahead head and sends it as an
//               asynchronous UART frame (start, data LSB first, optional
//               even parity, stop) on a registered, idle-high tx line.
//               Optional feature macro: FIFO_UART_TX_PARITY_EN (adds one
//               even-parity bit between the data bits and the stop bit).
// Ports       : clk       - single clock, all state on posedge
//               reset     - synchronous, active-high
//               fifo_data - FIFO head word (valid while fifo_val=1)
//               fifo_val  - FIFO non-empty
//               fifo_read - one-cycle pop strobe to the FIFO
//               tx        - serial line, idle high
//               busy      - frame in progress
//               tx_done   - pulse on the last cycle of the stop bit
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_val,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state,  w_state_next;
    logic [c_BAUD_W-1:0]   r_baud,   w_baud_next;
    logic [c_BIT_W-1:0]    r_bit,    w_bit_next;
    logic [DATA_WIDTH-1:0] r_shreg,  w_shreg_next;
    logic                  r_tx,     w_tx_next;
    logic                  w_bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    // Parity is captured at load time because the shift register is
    // consumed while the data bits go out.
    logic                  r_par,    w_par_next;
`endif

    assign w_bit_end = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + 1'b1;
        w_bit_next   = r_bit;
        w_shreg_next = r_shreg;
`ifdef FIFO_UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif
        fifo_read    = 1'b0;
        tx_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (fifo_val && !reset) begin
                    fifo_read    = 1'b1;
                    w_shreg_next = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    w_par_next   = ^fifo_data;
`endif
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_next = '0;
                    if (r_bit == c_BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                        w_shreg_next = r_shreg >> 1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_baud_next  = '0;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    tx_done      = 1'b1;
                    w_state_next = S_IDLE;
                    w_baud_next  = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
        endcase

        // tx is registered from the level of the state being entered, so the
        // line changes on the same edge as the state register.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shreg_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: w_tx_next = w_par_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shreg <= w_shreg_next;
            r_tx    <= w_tx_next;
`ifdef FIFO_UART_TX_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx. A queue stands in for
//               the ring FIFO; a frame-position model predicts tx, busy,
//               tx_done and fifo_read every cycle, and directed scenarios
//               add hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int DW = 8;
    localparam int C  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR          = 1;
    localparam int EXP_SPACING  = 45;
    localparam int EXP_A5_FRAME = 'h54A;
    localparam int EXP_07_FRAME = 'h60E;
`else
    localparam int PAR          = 0;
    localparam int EXP_SPACING  = 41;
    localparam int EXP_A5_FRAME = 'h34A;
    localparam int EXP_07_FRAME = 'h20E;
`endif
    localparam int NBITS = DW + 2 + PAR;
    localparam int FL    = NBITS * C;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_val = 1'b0;
    logic          fifo_read, tx, busy, tx_done;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_data (fifo_data),
        .fifo_val  (fifo_val),
        .fifo_read (fifo_read),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] popped[$];
    int            gaps[$];
    bit            pop_req = 0;
    bit            chk_en  = 0;
    int            cyc = 0;
    int            last_pop_cyc = -1;
    int            pop_cnt = 0;
    int            done_cnt = 0;

    // frame model: active flag, cycle position within frame, character
    bit            m_active = 0;
    int            m_pos = 0;
    logic [DW-1:0] m_char = '0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line level for frame bit index idx of character ch.
    function automatic logic frame_bit(input logic [DW-1:0] ch, input int idx);
        if (idx == 0)                  return 1'b0;
        if (idx <= DW)                 return ch[idx-1];
        if (PAR == 1 && idx == DW + 1) return ^ch;
        return 1'b1;
    endfunction

    task automatic refresh();
        fifo_val  = (fq.size() != 0);
        fifo_data = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // FIFO side: pop after the edge on which the DUT took the head word.
    always @(posedge clk) begin
        #1;
        if (pop_req) begin
            if (fq.size() != 0) void'(fq.pop_front());
            pop_req = 0;
        end
        refresh();
    end

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic exp_read, exp_tx, exp_busy, exp_done;
        cyc++;
        if (chk_en) begin
            exp_read = !m_active && fifo_val && !reset;
            if (m_active) begin
                exp_tx   = frame_bit(m_char, m_pos / C);
                exp_busy = 1'b1;
                exp_done = (m_pos == FL - 1);
            end else begin
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end
            check_bit("cyc_fifo_read", fifo_read, exp_read);
            check_bit("cyc_tx",        tx,        exp_tx);
            check_bit("cyc_busy",      busy,      exp_busy);
            check_bit("cyc_tx_done",   tx_done,   exp_done);

            if (fifo_read === 1'b1) begin
                pop_req = 1;
                pop_cnt++;
                popped.push_back(fifo_data);
                if (last_pop_cyc >= 0) gaps.push_back(cyc - last_pop_cyc);
                last_pop_cyc = cyc;
            end
            if (tx_done === 1'b1) done_cnt++;

            if (reset) begin
                m_active = 0;
            end else if (m_active) begin
                if (m_pos == FL - 1) m_active = 0;
                else                 m_pos++;
            end else if (exp_read) begin
                m_active = 1;
                m_pos    = 0;
                m_char   = fifo_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pop();
        bit ok = 0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (fifo_read === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) check_bit("wait_pop_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int t = 0; t < 600; t++) begin
            tick();
            if (busy === 1'b0 && fifo_read !== 1'b1 && fq.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check_bit("wait_idle_timeout", 1'b0, 1'b1);
    endtask

    // Send one byte and sample the middle of each bit on tx.
    task automatic send_capture(input logic [DW-1:0] ch, output int got);
        int cur = -1;
        got = 0;
        fq.push_back(ch);
        refresh();
        wait_pop();
        for (int k = 0; k < NBITS; k++) begin
            while (cur < k * C + C / 2) begin
                tick();
                cur++;
            end
            got = got | (int'(tx) << k);
        end
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0, d0, got, cur;

        // Reset hold with a non-empty FIFO
        fq.push_back(8'h11);
        refresh();
        @(posedge clk);
        #2;
        chk_en = 1;
        for (int i = 0; i < 3; i++) begin
            check_bit("rst_tx",        tx,        1'b1);
            check_bit("rst_fifo_read", fifo_read, 1'b0);
            check_bit("rst_busy",      busy,      1'b0);
            tick();
        end
        fq.delete();
        refresh();
        reset = 1'b0;
        tick();

        // Single byte 0xA5
        p0 = pop_cnt;
        d0 = done_cnt;
        send_capture(8'hA5, got);
        repeat (3) tick();
        check_int("a5_frame", got, EXP_A5_FRAME);
        check_int("a5_pops",  pop_cnt - p0, 1);
        check_int("a5_done",  done_cnt - d0, 1);

        // Byte 0x07 (odd weight; parity bit 1 when enabled)
        send_capture(8'h07, got);
        check_int("07_frame", got, EXP_07_FRAME);

        // Back-to-back from a preloaded FIFO
        gaps.delete();
        popped.delete();
        last_pop_cyc = -1;
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        fq.push_back(8'h55);
        refresh();
        wait_idle();
        check_int("b2b_npops",  popped.size(), 3);
        check_int("b2b_char0",  popped.size() > 0 ? int'(popped[0]) : -1, 'h00);
        check_int("b2b_char1",  popped.size() > 1 ? int'(popped[1]) : -1, 'hFF);
        check_int("b2b_char2",  popped.size() > 2 ? int'(popped[2]) : -1, 'h55);
        check_int("b2b_ngaps",  gaps.size(), 2);
        check_int("b2b_gap0",   gaps.size() > 0 ? gaps[0] : -1, EXP_SPACING);
        check_int("b2b_gap1",   gaps.size() > 1 ? gaps[1] : -1, EXP_SPACING);

        // Reset during data bit 3 of 0x3C; 0x99 must follow
        popped.delete();
        fq.push_back(8'h3C);
        fq.push_back(8'h99);
        refresh();
        wait_pop();
        cur = -1;
        while (cur < 4 * C + 1) begin
            tick();
            cur++;
        end
        check_bit("mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        check_bit("mid_tx_after",        tx,        1'b1);
        check_bit("mid_busy_after",      busy,      1'b0);
        check_bit("mid_fifo_read_inrst", fifo_read, 1'b0);
        reset = 1'b0;
        wait_idle();
        check_int("mid_npops", popped.size(), 2);
        check_int("mid_char0", popped.size() > 0 ? int'(popped[0]) : -1, 'h3C);
        check_int("mid_char1", popped.size() > 1 ? int'(popped[1]) : -1, 'h99);

        // Underflow guard: empty FIFO for 100 cycles
        p0 = pop_cnt;
        d0 = done_cnt;
        repeat (100) tick();
        check_int("uf_pops", pop_cnt - p0, 0);
        check_int("uf_done", done_cnt - d0, 0);
        check_bit("uf_tx",   tx,   1'b1);
        check_bit("uf_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
